thresh_queue: RTL and testbench

THRESH_QUEUE -- requirements
Module: thresh_queue

---
 rtl/thresh_queue.sv | 180 ++++++++++++++++++
 tb/tb_thresh_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/thresh_queue.sv
// thresh_queue -- synchronous FIFO with registered threshold flags and sticky
// overflow/underflow error flags.
//
// Build option: define THRESH_QUEUE_FWFT_EN for first-word-fall-through mode.
// In that mode data_out always shows the head entry and data_valid == !empty.
// Without it (default), a pop loads data_out at the edge and data_valid
// pulses for the following cycle only.
module thresh_queue #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 3,
  parameter int AF_THRESH     = (2 ** ADDRESS_WIDTH) - 2,
  parameter int AE_THRESH     = 1
) (
  input  logic                   sclk,
  input  logic                   reset,
  input  logic                   write_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   read_en,
  input  logic                   clear_err,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDRESS_WIDTH:0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;

  localparam logic [CW-1:0]            DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]            AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0]            AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0]            CNT_ONE = CW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

  // Flag values with an empty queue; almost_full is only set at count 0
  // when the threshold itself is 0 or below.
  localparam logic AF_AT_ZERO = (AF_THRESH <= 0);
  localparam logic AE_AT_ZERO = (AE_THRESH >= 0);

  // Storage; inferred as block RAM (no reset, registered read).
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDRESS_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]            count_reg, count_next;
  logic                     full_reg, empty_reg;
  logic                     almost_full_reg, almost_empty_reg;
  logic                     overflow_reg, overflow_next;
  logic                     underflow_reg, underflow_next;
  logic [DATA_WIDTH-1:0]    data_out_reg;
  logic                     data_valid_reg;

  logic push_ok;
  logic pop_ok;

  // Acceptance: a pop frees a slot, so a full queue can take a push in the
  // same cycle; a push into an empty queue cannot be popped in that cycle.
  assign pop_ok  = read_en & ~empty_reg;
  assign push_ok = write_en & (~full_reg | pop_ok);

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg & ~clear_err;
    underflow_next = underflow_reg & ~clear_err;

    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase

    // A fresh error in the clearing cycle keeps the flag set.
    if (write_en && !push_ok) begin
      overflow_next = 1'b1;
    end
    if (read_en && !pop_ok) begin
      underflow_next = 1'b1;
    end
  end

  // Pointer, count, status and error flag registers; flags track count_next
  // so they are always consistent with the registered count.
  always_ff @(posedge sclk) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= AF_AT_ZERO;
      almost_empty_reg <= AE_AT_ZERO;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      full_reg         <= (count_next == DEPTH_C);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_C);
      almost_empty_reg <= (count_next <= AE_C);
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
    end
  end

  // Storage write port; reset blocks the write so a push in the reset cycle
  // has no effect, but stored contents are never cleared.
  always_ff @(posedge sclk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

`ifdef THRESH_QUEUE_FWFT_EN
  logic load_from_in;
  logic load_from_mem;

  // The head register takes data_in when the pushed word becomes the new
  // head (queue empty, or last entry popped alongside a push); otherwise a
  // pop with more entries behind it fetches the next stored word.
  assign load_from_in  = push_ok & (empty_reg | (pop_ok & (count_reg == CNT_ONE)));
  assign load_from_mem = pop_ok & (count_reg > CNT_ONE);

  // Head-of-queue output register for first-word-fall-through.
  always_ff @(posedge sclk) begin
    if (reset) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      data_valid_reg <= (count_next != '0);
      if (load_from_in) begin
        data_out_reg <= data_in;
      end else if (load_from_mem) begin
        data_out_reg <= mem[rd_ptr_next];
      end
    end
  end
`else
  // Registered read: a pop loads the head entry and flags it valid for one
  // cycle; data_out holds its last value otherwise.
  always_ff @(posedge sclk) begin
    if (reset) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      data_valid_reg <= pop_ok;
      if (pop_ok) begin
        data_out_reg <= mem[rd_ptr_reg];
      end
    end
  end
`endif

  assign data_out     = data_out_reg;
  assign data_valid   = data_valid_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_thresh_queue.sv
// Testbench for thresh_queue: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model. Popped data is
// checked by a separate monitor through a scoreboard queue.
module tb_thresh_queue;

  localparam int DW    = 64;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 1;

  logic          sclk;
  logic          reset;
  logic          write_en;
  logic [DW-1:0] data_in;
  logic          read_en;
  logic          clear_err;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  thresh_queue #(
    .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(AW),
    .AF_THRESH(AFT),
    .AE_THRESH(AET)
  ) dut (
    .sclk(sclk),
    .reset(reset),
    .write_en(write_en),
    .data_in(data_in),
    .read_en(read_en),
    .clear_err(clear_err),
    .data_out(data_out),
    .data_valid(data_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  // Reference model state: stored entries in order, sticky flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  logic          m_ovf;
  logic          m_unf;

  int checks;
  int errors;
  int cyc;

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances on the same edge and the
  // status outputs are compared shortly after it.
  task automatic step(input logic we, input logic [DW-1:0] din, input logic re,
                      input logic clr, input logic rst);
    bit pop_ok;
    bit push_ok;
    logic [DW-1:0] popped;
    write_en  = we;
    data_in   = din;
    read_en   = re;
    clear_err = clr;
    reset     = rst;
    @(posedge sclk);
    cyc++;
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_ok  = re && (mq.size() > 0);
      push_ok = we && ((mq.size() < DEPTH) || pop_ok);
      m_ovf   = (m_ovf && !clr) || (we && !push_ok);
      m_unf   = (m_unf && !clr) || (re && !pop_ok);
      if (pop_ok) begin
        popped = mq.pop_front();
`ifndef THRESH_QUEUE_FWFT_EN
        sb.push_back(popped);
`endif
      end
      if (push_ok) mq.push_back(din);
    end
    #1;
    $display("cyc %0d rst=%0b we=%0b re=%0b clr=%0b din=%0h push=%0b pop=%0b count=%0d",
             cyc, rst, we, re, clr, din, push_ok, pop_ok, mq.size());
    chk("count", DW'(count), DW'(mq.size()));
    chk("full", DW'(full), DW'(mq.size() == DEPTH));
    chk("empty", DW'(empty), DW'(mq.size() == 0));
    chk("almost_full", DW'(almost_full), DW'(mq.size() >= AFT));
    chk("almost_empty", DW'(almost_empty), DW'(mq.size() <= AET));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("underflow", DW'(underflow), DW'(m_unf));
    if (rst) begin
      chk("reset_data_out", data_out, '0);
      chk("reset_data_valid", DW'(data_valid), '0);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Output monitor, sampling on the falling edge.
`ifdef THRESH_QUEUE_FWFT_EN
  always @(negedge sclk) begin
    if (!reset) begin
      chk("fwft_valid", DW'(data_valid), DW'(mq.size() != 0));
      if (mq.size() != 0) chk("fwft_head", data_out, mq[0]);
    end
  end
`else
  always @(negedge sclk) begin
    logic [DW-1:0] exp;
    if (data_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_extra cycle %0d: got valid data %0h required no output", cyc, data_out);
      end else begin
        exp = sb.pop_front();
        chk("pop_data", data_out, exp);
      end
    end
  end
`endif

  initial begin
    logic [DW-1:0] vals [4];
    int wp;
    int rp;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    clear_err = 1'b0;
    data_in   = '0;
    reset     = 1'b1;

    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Basic ordering.
    vals = '{64'd1, 64'd256, 64'd3325, 64'd0};
    for (int i = 0; i < 4; i++) push(vals[i]);
    for (int i = 0; i < 4; i++) pop();
    idle();

    // Fill past capacity, then drain to empty and underflow.
    for (int i = 10; i <= 18; i++) push(DW'(i));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    // Full with simultaneous push and pop: no overflow.
    step(1'b1, 64'd99, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pop();
    pop();
    idle();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    // Error and clear in the same cycle: flag stays set.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Wrap pointers with interleaved pops, reset after the 5th push.
    for (int i = 0; i < 12; i++) begin
      push(DW'(100 + i));
      if (i == 4) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (i % 2 == 1) pop();
    end
    for (int i = 0; i < 8; i++) pop();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    push(64'd7);
    idle();
    pop();
    idle();

    // FWFT-specific: head appears without read_en, pop empties it.
    push(64'd42);
    idle();
    pop();
    idle();

    // Randomized traffic with phases biased towards fill and drain.
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 3)
        0:       begin wp = 70; rp = 30; end
        1:       begin wp = 30; rp = 70; end
        default: begin wp = 50; rp = 50; end
      endcase
      step(($urandom_range(99) < wp), {$urandom, $urandom}, ($urandom_range(99) < rp),
           ($urandom_range(15) == 0), ($urandom_range(199) == 0));
    end
    idle();
    idle();

    chk("scoreboard_drained", DW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
